// File: rtl/cpu_wb_ctrl_pkg.sv
// Shared types for the writeback controller (cpu_wb_ctrl, optional macro CPU_WB_FWD_EN).
// Global CPU widths fall back to the cpu_define.v values only when that header was not loaded.
`ifndef CPU_XLEN
`define CPU_XLEN 32
`endif
`ifndef CPU_GREGIDX_WIDTH
`define CPU_GREGIDX_WIDTH 5
`endif
`ifndef CPU_GREG_COUNT
`define CPU_GREG_COUNT 32
`endif

package cpu_wb_ctrl_pkg;
  localparam int unsigned XLEN   = `CPU_XLEN;
  localparam int unsigned GIDX_W = `CPU_GREGIDX_WIDTH;
  localparam int unsigned GREG_N = `CPU_GREG_COUNT;

  typedef struct packed {
    logic [GIDX_W-1:0] idx;
    logic [XLEN-1:0]   dat;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LSU
  } wb_src_e;
endpackage

// File: rtl/cpu_wb_fifo.sv
// Result buffer for cpu_wb_ctrl: power-of-two ring with synchronous reset.
module cpu_wb_fifo
  import cpu_wb_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t din_i,
  output wb_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/cpu_wb_ctrl.sv
// Writeback controller: ALU/LSU result arbitration, result buffer, registered gregs write
// port and per-register pending scoreboard. Macro CPU_WB_FWD_EN adds write-port forwarding.
module cpu_wb_ctrl
  import cpu_wb_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned SB_CNT_W   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          iss_valid,
  output logic                          iss_ready,
  input  logic [`CPU_GREGIDX_WIDTH-1:0] iss_rd_idx,
  input  logic [`CPU_GREGIDX_WIDTH-1:0] rs1_idx,
  input  logic [`CPU_GREGIDX_WIDTH-1:0] rs2_idx,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
`ifdef CPU_WB_FWD_EN
  output logic                          rs1_fwd_hit,
  output logic [`CPU_XLEN-1:0]          rs1_fwd_dat,
  output logic                          rs2_fwd_hit,
  output logic [`CPU_XLEN-1:0]          rs2_fwd_dat,
`endif
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [`CPU_GREGIDX_WIDTH-1:0] alu_rd_idx,
  input  logic [`CPU_XLEN-1:0]          alu_dat,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [`CPU_GREGIDX_WIDTH-1:0] lsu_rd_idx,
  input  logic [`CPU_XLEN-1:0]          lsu_dat,
  output logic                          rd_wen,
  output logic [`CPU_GREGIDX_WIDTH-1:0] rd_idx,
  output logic [`CPU_XLEN-1:0]          rd_dat
);
  localparam logic [SB_CNT_W-1:0] SB_MAX = '1;
  localparam logic [SB_CNT_W-1:0] SB_ONE = SB_CNT_W'(1);

  wb_src_e      src;
  wb_entry_t    acc_entry, fifo_dout, rd_d;
  logic         acc_ready, acc_keep;
  logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic         rd_wen_q, rd_wen_d;
  logic [GIDX_W-1:0] rd_idx_q;
  logic [XLEN-1:0]   rd_dat_q;
  logic [SB_CNT_W-1:0] sb_cnt_q [GREG_N];
  logic [SB_CNT_W-1:0] sb_cnt_d [GREG_N];
  logic [SB_CNT_W-1:0] rs1_cnt, rs2_cnt;
  logic         iss_fire, rs1_hit, rs2_hit;

  assign fifo_pop  = !fifo_empty;
  assign acc_ready = !reset && (!fifo_full || fifo_pop);
  assign lsu_ready = acc_ready;
  assign alu_ready = acc_ready && !lsu_valid;

  always_comb begin
    src       = SRC_NONE;
    acc_entry = '0;
    if (lsu_valid && lsu_ready) begin
      src       = SRC_LSU;
      acc_entry = '{idx: lsu_rd_idx, dat: lsu_dat};
    end else if (alu_valid && alu_ready) begin
      src       = SRC_ALU;
      acc_entry = '{idx: alu_rd_idx, dat: alu_dat};
    end
    // x0 results complete the handshake but never occupy a slot or the write port.
    acc_keep  = (src != SRC_NONE) && (acc_entry.idx != '0);
    fifo_push = acc_keep && !fifo_empty;
    rd_wen_d  = !fifo_empty || acc_keep;
    rd_d      = fifo_empty ? acc_entry : fifo_dout;
  end

  cpu_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (acc_entry),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_wen_q <= 1'b0;
      rd_idx_q <= '0;
      rd_dat_q <= '0;
    end else begin
      rd_wen_q <= rd_wen_d;
      if (rd_wen_d) begin
        rd_idx_q <= rd_d.idx;
        rd_dat_q <= rd_d.dat;
      end
    end
  end

  assign rd_wen = rd_wen_q;
  assign rd_idx = rd_idx_q;
  assign rd_dat = rd_dat_q;

  assign iss_ready = !reset && ((iss_rd_idx == '0) || (sb_cnt_q[iss_rd_idx] != SB_MAX));
  assign iss_fire  = iss_valid && iss_ready && (iss_rd_idx != '0);

  always_comb begin
    sb_cnt_d    = sb_cnt_q;
    sb_cnt_d[0] = '0;
    for (int unsigned r = 1; r < GREG_N; r++) begin
      if (iss_fire && (iss_rd_idx == GIDX_W'(r))) begin
        if (!(rd_wen_q && (rd_idx_q == GIDX_W'(r)))) sb_cnt_d[r] = sb_cnt_q[r] + 1'b1;
      end else if (rd_wen_q && (rd_idx_q == GIDX_W'(r)) && (sb_cnt_q[r] != '0)) begin
        sb_cnt_d[r] = sb_cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < GREG_N; r++) sb_cnt_q[r] <= '0;
    end else begin
      sb_cnt_q <= sb_cnt_d;
    end
  end

  assign rs1_cnt = sb_cnt_q[rs1_idx];
  assign rs2_cnt = sb_cnt_q[rs2_idx];

`ifdef CPU_WB_FWD_EN
  assign rs1_hit     = rd_wen_q && (rd_idx_q == rs1_idx) && (rs1_idx != '0);
  assign rs2_hit     = rd_wen_q && (rd_idx_q == rs2_idx) && (rs2_idx != '0);
  assign rs1_fwd_hit = rs1_hit;
  assign rs2_fwd_hit = rs2_hit;
  assign rs1_fwd_dat = rd_dat_q;
  assign rs2_fwd_dat = rd_dat_q;
`else
  assign rs1_hit = 1'b0;
  assign rs2_hit = 1'b0;
`endif

  // The last outstanding write being forwarded this cycle no longer blocks the reader.
  assign rs1_busy = !reset && (rs1_idx != '0) && (rs1_cnt != '0) && !(rs1_hit && (rs1_cnt == SB_ONE));
  assign rs2_busy = !reset && (rs2_idx != '0) && (rs2_cnt != '0) && !(rs2_hit && (rs2_cnt == SB_ONE));
endmodule
